ps2_scancode_receiver: RTL
==========================

// Module: ps2_scancode_receiver
// PURPOSE
//  Receives PS/2 keyboard frames in the Clock domain. PS2_CLK and PS2_DATA are sampled as data, never used as clocks.
//  Checks start/parity/stop bits and folds E0/F0 prefixes into flags on the following code.
//  Buffers decoded key events in a FIFO read by game/VGA logic with a show-ahead valid/read handshake.
//  Replaces the PS2_CLK-clocked keyboard decoder; cursor/position logic moves downstream.
// PARAMETERS
//  FIFO_DEPTH      8      event entries; power of 2, >=2
//  SYNC_STAGES     2      flip-flop synchroniser depth on both PS/2 lines, >=2
//  FILTER_LEN      4      consecutive equal synced samples before filtered PS2_CLK changes, >=1
//  TIMEOUT_CYCLES  25000  Clock cycles with no PS2_CLK falling edge that abort a frame (1 ms at 25 MHz)
// PORTS
//  Clock          in   1                     system clock (25 MHz in current top)
//  Reset          in   1                     asynchronous, active-high; clears all state
//  iPS2_CLK       in   1                     raw PS/2 clock line, asynchronous
//  iPS2_DATA      in   1                     raw PS/2 data line, asynchronous
//  iRead          in   1                     pop head entry; ignored when oValid=0
//  oValid         out  1                     FIFO non-empty
//  oCode          out  8                     head scan code; 0 when empty
//  oBreak         out  1                     head entry preceded by F0 (key release); 0 when empty
//  oExtended      out  1                     head entry preceded by E0; 0 when empty
//  oCount         out  $clog2(FIFO_DEPTH)+1  entries stored
//  oOverflow      out  1                     sticky; event dropped because FIFO full; cleared only by Reset
//  oParityError   out  1                     one-Clock pulse; frame discarded for bad parity
//  oFrameError    out  1                     one-Clock pulse; bad stop bit or timeout
// BEHAVIOUR
//  Reset: all outputs 0; FSM IDLE; prefix flags, FIFO pointers, filter and timeout counters cleared.
//   Reset mid-frame drops the partial frame. No event or error pulse is issued for it.
//  Input path: SYNC_STAGES flip-flops per line. Filtered clock starts at 1 and takes a new value after FILTER_LEN equal samples.
//   Falling edge (fe) = filtered clock 1->0. The synced data bit is sampled in the fe cycle.
//  Frame FSM, one transition per fe:
//   IDLE  : fe & data=0 -> DATA (bit counter=0). fe & data=1 -> stay IDLE, no error.
//   DATA  : shift in LSB first; after 8th bit -> PARITY.
//   PARITY: store bit -> STOP.
//   STOP  : data=1 & odd parity (^code ^ parity == 1) -> accept byte. data=0 -> oFrameError.
//           stop ok but parity bad -> oParityError. Always -> IDLE.
//   Timeout counter runs in any state != IDLE and clears on each fe. Reaching TIMEOUT_CYCLES -> IDLE + oFrameError.
//  Prefix handling of accepted bytes:
//   E0 sets ext flag; F0 sets brk flag; neither is pushed.
//   Any other byte pushes {brk,ext,code} and clears both flags.
//   E0 F0 xx -> brk=1, ext=1. Error pulse -> both flags cleared.
//  Latency: push occurs the Clock after the STOP fe cycle, so oValid rises 2 Clocks after the stop-bit fe.
//  FIFO:
//   Show-ahead: oCode/oBreak/oExtended combinationally reflect the head entry.
//   Pop on iRead & oValid. iRead while empty is a no-op.
//   Push while full and not popping: event dropped, oOverflow set, contents unchanged.
//   Push and pop in the same cycle while full: both happen, oCount unchanged.
//   Push and pop in the same cycle while empty: not possible (oValid=0).
//   Pointers are $clog2(FIFO_DEPTH) bits and wrap naturally; full/empty come from oCount.
//  Widths: bit counter 3b; timeout counter $clog2(TIMEOUT_CYCLES+1)b, saturating; filter counter $clog2(FILTER_LEN+1)b.
// STRUCTURE
//  Shared header (Defintions.v):
//   `PS2_PREFIX_EXT 8'hE0, `PS2_PREFIX_BREAK 8'hF0
//   FSM encodings `PS2_IDLE/`PS2_DATA/`PS2_PARITY/`PS2_STOP
//   `PS2_EVT_W 10 (event = {brk,ext,code[7:0]})
//  Sub-module ps2_event_fifo #(WIDTH,DEPTH): synchronous FIFO, async Reset, show-ahead, count output.
//   Storage is not reset; head outputs are gated to 0 when empty.
//  Synchroniser, filter, FSM, timeout and prefix logic stay in this module.
// TESTING  (bench: 25 MHz Clock, PS/2 half-period 40 Clocks, TIMEOUT_CYCLES=400 override)
//  1 Frame 0x1C, parity 0, stop 1 -> oValid=1, oCode=1C, oBreak=0, oExtended=0, oCount=1; iRead -> oValid=0, oCode=0.
//  2 Bytes F0 1C, then E0 F0 74 -> two entries: {1,0,1C} then {1,1,74}; prefixes never appear as entries.
//  3 Frame 0x1C with parity 1 -> one oParityError pulse, no push. Frame with stop 0 -> one oFrameError pulse.
//     Next E0 then bad frame then 74 -> entry {0,0,74} (flag cleared by the error).
//  4 Stop toggling PS2_CLK after 4 data bits -> oFrameError pulse 400 Clocks after last fe.
//     A following good frame 0x29 -> entry 29.
//  5 Push FIFO_DEPTH+1 codes without reading -> oCount=8, oOverflow=1, first 8 codes read back in order.
//     Refill to full, send a code while asserting iRead at push -> oCount stays 8, new code last.
//  6 Assert Reset at bit 5 of a frame -> all outputs 0 next sample, no error pulse. Next full frame 0x5A received correctly.
//  7 1-Clock glitches on iPS2_CLK (shorter than FILTER_LEN) during IDLE and DATA -> no extra bits, no errors.

Source files
------------

// File: rtl/ps2_scancode_receiver_pkg.sv
// ---------------------------------------------------------------------------
// ps2_scancode_receiver_pkg
// Shared constants for the PS/2 scan-code receiver: prefix bytes, frame FSM
// encodings, key-event width and the odd-parity helper.
// No ports (package).
// ---------------------------------------------------------------------------
package ps2_scancode_receiver_pkg;

  localparam logic [7:0] PS2_PREFIX_EXT   = 8'hE0;
  localparam logic [7:0] PS2_PREFIX_BREAK = 8'hF0;

  // Frame FSM encodings
  localparam logic [1:0] PS2_IDLE   = 2'd0;
  localparam logic [1:0] PS2_DATA   = 2'd1;
  localparam logic [1:0] PS2_PARITY = 2'd2;
  localparam logic [1:0] PS2_STOP   = 2'd3;

  // Key event = {brk, ext, code[7:0]}
  localparam int PS2_EVT_W = 10;

  // PS/2 uses odd parity: data bits plus parity bit must hold an odd number of ones.
  function automatic logic odd_parity_ok(input logic [7:0] code, input logic par);
    return (^code) ^ par;
  endfunction

endpackage

// File: rtl/ps2_event_fifo.sv
// ---------------------------------------------------------------------------
// ps2_event_fifo
// Synchronous show-ahead FIFO for decoded key events.
// Ports:
//   Clock, Reset   system clock, asynchronous active-high reset
//   i_push         write request; i_push_data is the entry
//   i_pop          read request; ignored while empty
//   o_valid        FIFO non-empty
//   o_data         head entry, 0 while empty
//   o_count        number of stored entries
//   o_overflow     sticky: a push was dropped because the FIFO was full
// Handshake: o_data is valid whenever o_valid=1; an entry is consumed on
// every rising Clock edge where i_pop=1 and o_valid=1.
// ---------------------------------------------------------------------------
module ps2_event_fifo #(
  parameter int WIDTH = 10,
  parameter int DEPTH = 8
) (
  input  logic                     Clock,
  input  logic                     Reset,
  input  logic                     i_push,
  input  logic [WIDTH-1:0]         i_push_data,
  input  logic                     i_pop,
  output logic                     o_valid,
  output logic [WIDTH-1:0]         o_data,
  output logic [$clog2(DEPTH):0]   o_count,
  output logic                     o_overflow
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wptr;
  logic [AW-1:0]    r_rptr;
  logic [CW-1:0]    r_count;
  logic             r_overflow;

  logic w_empty;
  logic w_full;
  logic w_pop;
  logic w_push;

  assign w_empty = (r_count == '0);
  assign w_full  = (r_count == CW'(DEPTH));
  assign w_pop   = i_pop & ~w_empty;
  // A pop in the same cycle frees the slot, so a push into a full FIFO still lands.
  assign w_push  = i_push & (~w_full | w_pop);

  // Storage carries no reset; empty entries are never visible at the head.
  always_ff @(posedge Clock) begin
    if (w_push) r_mem[r_wptr] <= i_push_data;
  end

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      r_wptr     <= '0;
      r_rptr     <= '0;
      r_count    <= '0;
      r_overflow <= 1'b0;
    end else begin
      if (w_push) r_wptr <= r_wptr + AW'(1);
      if (w_pop)  r_rptr <= r_rptr + AW'(1);
      if (w_push && !w_pop)      r_count <= r_count + CW'(1);
      else if (w_pop && !w_push) r_count <= r_count - CW'(1);
      if (i_push && w_full && !w_pop) r_overflow <= 1'b1;
    end
  end

  assign o_valid    = ~w_empty;
  assign o_data     = w_empty ? '0 : r_mem[r_rptr];
  assign o_count    = r_count;
  assign o_overflow = r_overflow;

endmodule

// File: rtl/ps2_scancode_receiver.sv
// ---------------------------------------------------------------------------
// ps2_scancode_receiver
// Receives PS/2 keyboard frames in the Clock domain (PS/2 lines are sampled
// as data), checks start/parity/stop, folds E0/F0 prefixes into flags and
// queues key events in a show-ahead FIFO.
// Ports:
//   Clock, Reset        system clock, asynchronous active-high reset
//   iPS2_CLK/iPS2_DATA  raw asynchronous PS/2 lines
//   iRead               pop head event (ignored while oValid=0)
//   oValid              an event is available
//   oCode/oBreak/oExtended  head event fields, 0 while empty
//   oCount              stored events
//   oOverflow           sticky: event dropped on full FIFO
//   oParityError        one-Clock pulse: frame discarded for bad parity
//   oFrameError         one-Clock pulse: bad stop bit or inter-bit timeout
// Handshake: oCode/oBreak/oExtended are valid whenever oValid=1; the head is
// consumed on each rising Clock edge with iRead=1 and oValid=1.
// ---------------------------------------------------------------------------
module ps2_scancode_receiver
  import ps2_scancode_receiver_pkg::*;
#(
  parameter int FIFO_DEPTH     = 8,
  parameter int SYNC_STAGES    = 2,
  parameter int FILTER_LEN     = 4,
  parameter int TIMEOUT_CYCLES = 25000
) (
  input  logic                          Clock,
  input  logic                          Reset,
  input  logic                          iPS2_CLK,
  input  logic                          iPS2_DATA,
  input  logic                          iRead,
  output logic                          oValid,
  output logic [7:0]                    oCode,
  output logic                          oBreak,
  output logic                          oExtended,
  output logic [$clog2(FIFO_DEPTH):0]   oCount,
  output logic                          oOverflow,
  output logic                          oParityError,
  output logic                          oFrameError
);

  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam int FW = $clog2(FILTER_LEN + 1);
  localparam logic [TW-1:0] TMO_MAX  = TW'(TIMEOUT_CYCLES);
  localparam logic [FW-1:0] FILT_END = FW'(FILTER_LEN - 1);

  // Synchronisers; reset to the idle-high line level so no edge is seen at reset release.
  logic [SYNC_STAGES-1:0] r_clk_sync;
  logic [SYNC_STAGES-1:0] r_data_sync;
  logic                   w_clk_s;
  logic                   w_data_s;

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      r_clk_sync  <= '1;
      r_data_sync <= '1;
    end else begin
      r_clk_sync  <= {r_clk_sync[SYNC_STAGES-2:0],  iPS2_CLK};
      r_data_sync <= {r_data_sync[SYNC_STAGES-2:0], iPS2_DATA};
    end
  end

  assign w_clk_s  = r_clk_sync[SYNC_STAGES-1];
  assign w_data_s = r_data_sync[SYNC_STAGES-1];

  // Glitch filter: the filtered clock follows only after FILTER_LEN
  // consecutive samples that disagree with it.
  logic          r_filt_clk;
  logic [FW-1:0] r_filt_cnt;
  logic          w_fe;

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      r_filt_clk <= 1'b1;
      r_filt_cnt <= '0;
    end else if (w_clk_s == r_filt_clk) begin
      r_filt_cnt <= '0;
    end else if (r_filt_cnt == FILT_END) begin
      r_filt_clk <= w_clk_s;
      r_filt_cnt <= '0;
    end else begin
      r_filt_cnt <= r_filt_cnt + FW'(1);
    end
  end

  // Falling edge is flagged in the cycle the filtered clock is about to drop.
  assign w_fe = r_filt_clk & ~w_clk_s & (r_filt_cnt == FILT_END);

  // Frame FSM
  logic [1:0]    r_state;
  logic [2:0]    r_bit_cnt;
  logic [7:0]    r_shift;
  logic          r_parity;
  logic [TW-1:0] r_tmo;
  logic          r_byte_valid;
  logic [7:0]    r_byte;
  logic          r_parity_err;
  logic          r_frame_err;

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      r_state      <= PS2_IDLE;
      r_bit_cnt    <= '0;
      r_shift      <= '0;
      r_parity     <= 1'b0;
      r_tmo        <= '0;
      r_byte_valid <= 1'b0;
      r_byte       <= '0;
      r_parity_err <= 1'b0;
      r_frame_err  <= 1'b0;
    end else begin
      r_byte_valid <= 1'b0;
      r_parity_err <= 1'b0;
      r_frame_err  <= 1'b0;

      if (r_state == PS2_IDLE || w_fe) r_tmo <= '0;
      else if (r_tmo != TMO_MAX)       r_tmo <= r_tmo + TW'(1);

      if (r_state != PS2_IDLE && !w_fe && r_tmo == TMO_MAX) begin
        r_state     <= PS2_IDLE;
        r_frame_err <= 1'b1;
      end else if (w_fe) begin
        case (r_state)
          PS2_IDLE: begin
            // A high start bit is treated as line noise, not an error.
            if (!w_data_s) begin
              r_state   <= PS2_DATA;
              r_bit_cnt <= '0;
            end
          end
          PS2_DATA: begin
            r_shift   <= {w_data_s, r_shift[7:1]};
            r_bit_cnt <= r_bit_cnt + 3'd1;
            if (r_bit_cnt == 3'd7) r_state <= PS2_PARITY;
          end
          PS2_PARITY: begin
            r_parity <= w_data_s;
            r_state  <= PS2_STOP;
          end
          PS2_STOP: begin
            if (!w_data_s)                           r_frame_err  <= 1'b1;
            else if (odd_parity_ok(r_shift, r_parity)) begin
              r_byte_valid <= 1'b1;
              r_byte       <= r_shift;
            end else                                 r_parity_err <= 1'b1;
            r_state <= PS2_IDLE;
          end
          default: r_state <= PS2_IDLE;
        endcase
      end
    end
  end

  // Prefix folding: E0/F0 only set flags, the next real code carries them.
  logic r_ext;
  logic r_brk;
  logic w_push;
  logic [PS2_EVT_W-1:0] w_push_data;

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      r_ext <= 1'b0;
      r_brk <= 1'b0;
    end else if (r_parity_err || r_frame_err) begin
      r_ext <= 1'b0;
      r_brk <= 1'b0;
    end else if (r_byte_valid) begin
      if (r_byte == PS2_PREFIX_EXT)        r_ext <= 1'b1;
      else if (r_byte == PS2_PREFIX_BREAK) r_brk <= 1'b1;
      else begin
        r_ext <= 1'b0;
        r_brk <= 1'b0;
      end
    end
  end

  assign w_push      = r_byte_valid && (r_byte != PS2_PREFIX_EXT) && (r_byte != PS2_PREFIX_BREAK);
  assign w_push_data = {r_brk, r_ext, r_byte};

  logic [PS2_EVT_W-1:0] w_head;

  ps2_event_fifo #(
    .WIDTH (PS2_EVT_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .Clock       (Clock),
    .Reset       (Reset),
    .i_push      (w_push),
    .i_push_data (w_push_data),
    .i_pop       (iRead),
    .o_valid     (oValid),
    .o_data      (w_head),
    .o_count     (oCount),
    .o_overflow  (oOverflow)
  );

  assign oCode        = w_head[7:0];
  assign oExtended    = w_head[8];
  assign oBreak       = w_head[9];
  assign oParityError = r_parity_err;
  assign oFrameError  = r_frame_err;

endmodule
